// File: rtl/pmp_iter_checker.sv
// pmp_iter_checker: multi-cycle PMP checker for the memory-access path.
// Scans EntriesPerCycle pmpcfg/pmpaddr pairs per cycle in priority order and
// returns allow/deny with the winning entry index. A sticky record of the
// first denied access is kept for trap reporting.
// Each conf_i element uses the RISC-V pmpcfg byte layout:
//   [7] locked, [6:5] reserved, [4:3] addr_mode (OFF/TOR/NA4/NAPOT), [2:0] access_type (X,W,R).
module pmp_iter_checker #(
  parameter int unsigned NrPMPEntries    = 16,
  parameter int unsigned EntriesPerCycle = 4,
  parameter int unsigned PLEN            = 34
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic                                       req_valid_i,
  output logic                                       req_ready_o,
  input  logic [PLEN-1:0]                            req_addr_i,
  input  logic [2:0]                                 req_access_i,
  input  logic [1:0]                                 req_priv_i,
  input  logic [NrPMPEntries-1:0][PLEN-3:0]          conf_addr_i,
  input  logic [NrPMPEntries-1:0][7:0]               conf_i,
  input  logic                                       flush_i,
  output logic                                       rsp_valid_o,
  input  logic                                       rsp_ready_i,
  output logic                                       rsp_allow_o,
  output logic                                       rsp_matched_o,
  output logic [$clog2(NrPMPEntries)-1:0]            rsp_idx_o,
  output logic                                       fault_valid_o,
  output logic [PLEN-1:0]                            fault_addr_o,
  output logic [2:0]                                 fault_access_o,
  input  logic                                       fault_clear_i
);

  localparam int unsigned Groups = NrPMPEntries / EntriesPerCycle;
  localparam int unsigned GrpW   = (Groups > 1) ? $clog2(Groups) : 1;
  localparam int unsigned IdxW   = $clog2(NrPMPEntries);
  localparam int unsigned AW     = PLEN - 2;

  localparam int unsigned CfgLockBit = 7;
  localparam logic [1:0]  ModeOff    = 2'd0;
  localparam logic [1:0]  ModeTor    = 2'd1;
  localparam logic [1:0]  ModeNa4    = 2'd2;
  localparam logic [1:0]  ModeNapot  = 2'd3;
  localparam logic [1:0]  PrivM      = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESP
  } state_e;

  state_e              state_q, state_d;
  logic [GrpW-1:0]     g_q, g_d;
  logic [PLEN-1:0]     addr_q, addr_d;
  logic [2:0]          access_q, access_d;
  logic [1:0]          priv_q, priv_d;
  logic                allow_q, allow_d;
  logic                matched_q, matched_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                fault_valid_q, fault_valid_d;
  logic [PLEN-1:0]     fault_addr_q, fault_addr_d;
  logic [2:0]          fault_access_q, fault_access_d;

  logic [AW-1:0]           req_word;
  logic [NrPMPEntries-1:0] entry_hit;
  logic                    win;
  logic [IdxW-1:0]         win_idx;
  logic [2:0]              win_perm;
  logic                    rsp_hs;

  logic [NrPMPEntries-1:0][1:0] unused_cfg_rsvd;

  assign req_word = addr_q[PLEN-1:2];

  // Reserved pmpcfg bits carry no meaning for the check
  always_comb begin
    for (int i = 0; i < NrPMPEntries; i++) begin
      unused_cfg_rsvd[i] = conf_i[i][6:5];
    end
  end

  for (genvar i = 0; i < NrPMPEntries; i++) begin : g_entry
    logic [AW-1:0] prev_addr;
    logic [AW-1:0] napot_mask;
    logic          addr_match;
    logic          applicable;
    logic          in_group;

    if (i == 0) begin : g_first
      assign prev_addr = '0;
    end else begin : g_rest
      assign prev_addr = conf_addr_i[i-1];
    end

    // Low bits up to and including the first zero; all-ones pmpaddr masks everything
    assign napot_mask = conf_addr_i[i] ^ (conf_addr_i[i] + AW'(1));
    assign applicable = (priv_q != PrivM) || conf_i[i][CfgLockBit];
    assign in_group   = (g_q == GrpW'(i / EntriesPerCycle));

    // Address match of the latched request word against this entry
    always_comb begin
      case (conf_i[i][4:3])
        ModeTor:   addr_match = (req_word >= prev_addr) && (req_word < conf_addr_i[i]);
        ModeNa4:   addr_match = (req_word == conf_addr_i[i]);
        ModeNapot: addr_match = ((req_word ^ conf_addr_i[i]) & ~napot_mask) == '0;
        ModeOff:   addr_match = 1'b0;
        default:   addr_match = 1'b0;
      endcase
    end

    assign entry_hit[i] = in_group && applicable && addr_match;
  end

  // Lowest-index hit within the current group wins
  always_comb begin
    win     = 1'b0;
    win_idx = '0;
    for (int i = NrPMPEntries - 1; i >= 0; i--) begin
      if (entry_hit[i]) begin
        win     = 1'b1;
        win_idx = IdxW'(i);
      end
    end
  end

  assign win_perm    = conf_i[win_idx][2:0];
  assign req_ready_o = (state_q == IDLE) && !flush_i;
  assign rsp_hs      = (state_q == RESP) && rsp_ready_i && !flush_i;

  // Next-state, request latching, response and fault-record update
  always_comb begin
    state_d        = state_q;
    g_d            = g_q;
    addr_d         = addr_q;
    access_d       = access_q;
    priv_d         = priv_q;
    allow_d        = allow_q;
    matched_d      = matched_q;
    idx_d          = idx_q;
    fault_valid_d  = fault_valid_q;
    fault_addr_d   = fault_addr_q;
    fault_access_d = fault_access_q;

    case (state_q)
      IDLE: begin
        if (req_valid_i && req_ready_o) begin
          addr_d   = req_addr_i;
          access_d = req_access_i;
          priv_d   = req_priv_i;
          g_d      = '0;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (win) begin
          allow_d   = ((access_q & win_perm) == access_q);
          matched_d = 1'b1;
          idx_d     = win_idx;
          state_d   = RESP;
        end else if (g_q == GrpW'(Groups - 1)) begin
          allow_d   = (priv_q == PrivM);
          matched_d = 1'b0;
          idx_d     = '0;
          state_d   = RESP;
        end else begin
          g_d = g_q + GrpW'(1);
        end
      end
      RESP: begin
        if (flush_i || rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rsp_hs && !allow_q && (!fault_valid_q || fault_clear_i)) begin
      fault_valid_d  = 1'b1;
      fault_addr_d   = addr_q;
      fault_access_d = access_q;
    end else if (fault_clear_i) begin
      fault_valid_d = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      g_q            <= '0;
      addr_q         <= '0;
      access_q       <= '0;
      priv_q         <= '0;
      allow_q        <= 1'b0;
      matched_q      <= 1'b0;
      idx_q          <= '0;
      fault_valid_q  <= 1'b0;
      fault_addr_q   <= '0;
      fault_access_q <= '0;
    end else begin
      state_q        <= state_d;
      g_q            <= g_d;
      addr_q         <= addr_d;
      access_q       <= access_d;
      priv_q         <= priv_d;
      allow_q        <= allow_d;
      matched_q      <= matched_d;
      idx_q          <= idx_d;
      fault_valid_q  <= fault_valid_d;
      fault_addr_q   <= fault_addr_d;
      fault_access_q <= fault_access_d;
    end
  end

  assign rsp_valid_o    = (state_q == RESP);
  assign rsp_allow_o    = allow_q;
  assign rsp_matched_o  = matched_q;
  assign rsp_idx_o      = idx_q;
  assign fault_valid_o  = fault_valid_q;
  assign fault_addr_o   = fault_addr_q;
  assign fault_access_o = fault_access_q;

endmodule

// File: tb/tb_pmp_iter_checker.sv
// Testbench for pmp_iter_checker: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a transaction-level model.
module tb_pmp_iter_checker;

  localparam int N    = 16;
  localparam int E    = 4;
  localparam int PLEN = 34;
  localparam int G    = N / E;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 req_valid_i = 1'b0;
  logic                 req_ready_o;
  logic [PLEN-1:0]      req_addr_i = '0;
  logic [2:0]           req_access_i = '0;
  logic [1:0]           req_priv_i = '0;
  logic [N-1:0][31:0]   conf_addr_i;
  logic [N-1:0][7:0]    conf_i;
  logic                 flush_i = 1'b0;
  logic                 rsp_valid_o;
  logic                 rsp_ready_i = 1'b1;
  logic                 rsp_allow_o;
  logic                 rsp_matched_o;
  logic [3:0]           rsp_idx_o;
  logic                 fault_valid_o;
  logic [PLEN-1:0]      fault_addr_o;
  logic [2:0]           fault_access_o;
  logic                 fault_clear_i = 1'b0;

  logic [1:0]  cfgMode [N];
  bit          cfgLock [N];
  logic [2:0]  cfgPerm [N];
  logic [31:0] cfgAddr [N];

  int testsRun = 0;
  int failures = 0;
  int cyc = 0;

  // Transaction-level model state
  bit              mdlPending = 0;
  bit              mdlRespValid = 0;
  int              mdlCount = 0;
  bit              mdlAllow = 0;
  bit              mdlMatched = 0;
  int              mdlIdx = 0;
  int              mdlLat = 0;
  bit              mdlHs = 0;
  logic [PLEN-1:0] mdlReqAddr = '0;
  logic [2:0]      mdlReqAccess = '0;
  bit              mdlFaultValid = 0;
  logic [PLEN-1:0] mdlFaultAddr = '0;
  logic [2:0]      mdlFaultAccess = '0;

  pmp_iter_checker #(
    .NrPMPEntries(N),
    .EntriesPerCycle(E),
    .PLEN(PLEN)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i),
    .req_access_i(req_access_i),
    .req_priv_i(req_priv_i),
    .conf_addr_i(conf_addr_i),
    .conf_i(conf_i),
    .flush_i(flush_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_allow_o(rsp_allow_o),
    .rsp_matched_o(rsp_matched_o),
    .rsp_idx_o(rsp_idx_o),
    .fault_valid_o(fault_valid_o),
    .fault_addr_o(fault_addr_o),
    .fault_access_o(fault_access_o),
    .fault_clear_i(fault_clear_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pack the per-entry configuration into pmpcfg bytes and pmpaddr words
  always_comb begin
    for (int i = 0; i < N; i++) begin
      conf_addr_i[i] = cfgAddr[i];
      conf_i[i]      = {cfgLock[i], 2'b00, cfgMode[i], cfgPerm[i]};
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Reference decision: first applicable matching entry, plus the cycles until the result shows
  function automatic void refCheck(input logic [PLEN-1:0] addr, input logic [2:0] acc, input logic [1:0] priv,
                                   output bit allow, output bit matched, output int idx, output int lat);
    longint a;
    longint pa;
    longint prev;
    longint size;
    longint base;
    int     t;
    bit     hit;
    a       = longint'(addr[PLEN-1:2]);
    allow   = (priv == 2'b11);
    matched = 0;
    idx     = 0;
    lat     = G + 1;
    for (int i = 0; i < N; i++) begin
      pa   = longint'(cfgAddr[i]);
      prev = (i == 0) ? 0 : longint'(cfgAddr[i-1]);
      hit  = 0;
      if (cfgMode[i] == 2'd1) begin
        hit = (a >= prev) && (a < pa);
      end else if (cfgMode[i] == 2'd2) begin
        hit = (a == pa);
      end else if (cfgMode[i] == 2'd3) begin
        t = 0;
        while (t < 32 && cfgAddr[i][t]) t++;
        if (t >= 32) begin
          hit = 1;
        end else begin
          size = longint'(1) << (t + 1);
          base = (pa / size) * size;
          hit  = (a >= base) && (a < base + size);
        end
      end
      if (hit && (priv != 2'b11 || cfgLock[i])) begin
        matched = 1;
        idx     = i;
        allow   = ((acc & cfgPerm[i]) == acc);
        lat     = i / E + 2;
        break;
      end
    end
  endfunction

  // Model advances on the same edges the design samples its inputs
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdlPending     = 0;
      mdlRespValid   = 0;
      mdlFaultValid  = 0;
      mdlFaultAddr   = '0;
      mdlFaultAccess = '0;
    end else begin
      mdlHs = mdlRespValid && rsp_ready_i && !flush_i;
      if (mdlHs && !mdlAllow && (!mdlFaultValid || fault_clear_i)) begin
        mdlFaultValid  = 1;
        mdlFaultAddr   = mdlReqAddr;
        mdlFaultAccess = mdlReqAccess;
      end else if (fault_clear_i) begin
        mdlFaultValid = 0;
      end
      if (mdlPending) begin
        if (flush_i || mdlHs) begin
          mdlPending   = 0;
          mdlRespValid = 0;
        end else if (!mdlRespValid) begin
          mdlCount--;
          if (mdlCount == 0) mdlRespValid = 1;
        end
      end else if (req_valid_i && !flush_i) begin
        refCheck(req_addr_i, req_access_i, req_priv_i, mdlAllow, mdlMatched, mdlIdx, mdlLat);
        mdlReqAddr   = req_addr_i;
        mdlReqAccess = req_access_i;
        mdlPending   = 1;
        mdlRespValid = 0;
        mdlCount     = mdlLat - 1;
      end
    end
  end

  // Per-cycle comparison of every meaningful output against the model
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("req_ready", req_ready_o, !mdlPending && !flush_i);
      checkOutput("rsp_valid", rsp_valid_o, mdlRespValid);
      if (mdlRespValid) begin
        checkOutput("rsp_allow", rsp_allow_o, mdlAllow);
        checkOutput("rsp_matched", rsp_matched_o, mdlMatched);
        checkOutput("rsp_idx", rsp_idx_o, mdlIdx);
      end
      checkOutput("fault_valid", fault_valid_o, mdlFaultValid);
      if (mdlFaultValid) begin
        checkOutput("fault_addr", fault_addr_o, mdlFaultAddr);
        checkOutput("fault_access", fault_access_o, mdlFaultAccess);
      end
    end
  end

  task automatic clearConfig();
    for (int i = 0; i < N; i++) begin
      cfgMode[i] = 2'd0;
      cfgLock[i] = 0;
      cfgPerm[i] = 3'd0;
      cfgAddr[i] = 32'd0;
    end
  endtask

  task automatic randomConfig();
    for (int i = 0; i < N; i++) begin
      cfgMode[i] = 2'($urandom_range(0, 3));
      cfgLock[i] = 1'($urandom_range(0, 1));
      cfgPerm[i] = 3'($urandom_range(0, 7));
      cfgAddr[i] = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 80));
    end
  endtask

  function automatic logic [PLEN-1:0] randAddr();
    logic [31:0] a;
    if ($urandom_range(0, 9) == 0) a = $urandom;
    else a = 32'($urandom_range(0, 80));
    return {a, 2'($urandom_range(0, 3))};
  endfunction

  task automatic applyStimulus(input logic [PLEN-1:0] addr, input logic [2:0] acc, input logic [1:0] priv,
                               output int acceptCyc);
    bit got;
    got          = 0;
    acceptCyc    = 0;
    req_addr_i   = addr;
    req_access_i = acc;
    req_priv_i   = priv;
    req_valid_i  = 1'b1;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (req_ready_o) begin
        got       = 1;
        acceptCyc = cyc;
      end
      @(posedge clk);
      #1;
    end
    req_valid_i = 1'b0;
    checkOutput("accept_timeout", got, 1);
  endtask

  task automatic waitResp(output int respCyc, output bit seen);
    seen    = 0;
    respCyc = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (rsp_valid_o) begin
        seen    = 1;
        respCyc = cyc;
      end
    end
  endtask

  task automatic runDirected(input string name, input logic [PLEN-1:0] addr, input logic [2:0] acc,
                             input logic [1:0] priv, input bit expAllow, input bit expMatched,
                             input int expIdx, input int expLat, input bit clearAtResp);
    int acc0;
    int rc;
    bit seen;
    rsp_ready_i = 1'b1;
    applyStimulus(addr, acc, priv, acc0);
    waitResp(rc, seen);
    checkOutput({name, "_seen"}, seen, 1);
    if (seen) begin
      checkOutput({name, "_latency"}, 64'(rc - acc0), 64'(expLat));
      checkOutput({name, "_allow"}, rsp_allow_o, expAllow);
      checkOutput({name, "_matched"}, rsp_matched_o, expMatched);
      checkOutput({name, "_idx"}, rsp_idx_o, 64'(expIdx));
    end
    fault_clear_i = clearAtResp;
    @(posedge clk);
    #1;
    fault_clear_i = 1'b0;
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, "_rsp_valid"}, rsp_valid_o, 0);
    checkOutput({name, "_rsp_allow"}, rsp_allow_o, 0);
    checkOutput({name, "_rsp_matched"}, rsp_matched_o, 0);
    checkOutput({name, "_rsp_idx"}, rsp_idx_o, 0);
    checkOutput({name, "_fault_valid"}, fault_valid_o, 0);
    checkOutput({name, "_fault_addr"}, fault_addr_o, 0);
    checkOutput({name, "_fault_access"}, fault_access_o, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc0;
    int rc;
    bit seen;
    clearConfig();
    #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_req_ready", req_ready_o, 1);
    @(posedge clk);
    #1;

    // All entries OFF: U-mode read denied after a full scan
    runDirected("all_off", 34'h0_8000_0000, 3'b001, 2'b00, 0, 0, 0, 5, 0);
    checkOutput("all_off_fault_valid", fault_valid_o, 1);
    checkOutput("all_off_fault_addr", fault_addr_o, 34'h0_8000_0000);
    checkOutput("all_off_fault_access", fault_access_o, 3'b001);

    // 8 KiB NAPOT region at 0x8000_0000 with R|X
    clearConfig();
    cfgMode[0] = 2'd3;
    cfgPerm[0] = 3'b101;
    cfgAddr[0] = (32'h8000_0000 >> 2) | 32'h3FF;
    runDirected("napot_write", 34'h0_8000_1000, 3'b010, 2'b01, 0, 1, 0, 2, 0);
    runDirected("napot_exec", 34'h0_8000_1000, 3'b100, 2'b01, 1, 1, 0, 2, 0);

    // Priority across groups: TOR in entry 5 beats NA4 in entry 9
    clearConfig();
    cfgAddr[4] = 32'h400;
    cfgMode[5] = 2'd1;
    cfgAddr[5] = 32'h800;
    cfgPerm[5] = 3'b011;
    cfgMode[9] = 2'd2;
    cfgAddr[9] = 32'h1800 >> 2;
    runDirected("priority", 34'h0_0000_1800, 3'b001, 2'b00, 1, 1, 5, 3, 0);

    // M-mode ignores unlocked entries, honours locked ones
    clearConfig();
    cfgMode[2] = 2'd2;
    cfgAddr[2] = 32'h100 >> 2;
    runDirected("m_unlocked", 34'h0_0000_0100, 3'b001, 2'b11, 1, 0, 0, 5, 0);
    cfgLock[2] = 1;
    runDirected("m_locked", 34'h0_0000_0100, 3'b001, 2'b11, 0, 1, 2, 2, 0);

    // Backpressure: response held stable while not accepted
    clearConfig();
    cfgMode[0] = 2'd3;
    cfgPerm[0] = 3'b101;
    cfgAddr[0] = (32'h8000_0000 >> 2) | 32'h3FF;
    rsp_ready_i = 1'b0;
    applyStimulus(34'h0_8000_1000, 3'b100, 2'b01, acc0);
    waitResp(rc, seen);
    checkOutput("bp_seen", seen, 1);
    for (int k = 0; k < 3; k++) begin
      checkOutput("bp_valid", rsp_valid_o, 1);
      checkOutput("bp_allow", rsp_allow_o, 1);
      checkOutput("bp_matched", rsp_matched_o, 1);
      checkOutput("bp_idx", rsp_idx_o, 0);
      checkOutput("bp_req_ready", req_ready_o, 0);
      @(negedge clk);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("bp_released", rsp_valid_o, 0);
    checkOutput("bp_ready_again", req_ready_o, 1);
    @(posedge clk);
    #1;

    // Flush mid-scan discards the request without touching the fault record
    clearConfig();
    applyStimulus(34'h0_0000_0200, 3'b001, 2'b00, acc0);
    @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(negedge clk);
    checkOutput("flush_ready_low", req_ready_o, 0);
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    @(negedge clk);
    checkOutput("flush_idle_ready", req_ready_o, 1);
    for (int k = 0; k < 6; k++) begin
      checkOutput("flush_no_rsp", rsp_valid_o, 0);
      @(negedge clk);
    end
    checkOutput("flush_fault_kept", fault_addr_o, 34'h0_8000_0000);
    @(posedge clk);
    #1;

    // Reset mid-scan forces reset values immediately
    applyStimulus(34'h0_0000_0000, 3'b001, 2'b00, acc0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkResetValues("midscan_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midscan_reset_ready", req_ready_o, 1);
    @(posedge clk);
    #1;

    // Sticky first fault, and clear coinciding with a new denial
    runDirected("sticky_a", 34'h0_0000_0100, 3'b001, 2'b00, 0, 0, 0, 5, 0);
    checkOutput("sticky_first", fault_addr_o, 34'h100);
    runDirected("sticky_b", 34'h0_0000_0200, 3'b001, 2'b00, 0, 0, 0, 5, 0);
    checkOutput("sticky_kept", fault_addr_o, 34'h100);
    runDirected("sticky_c", 34'h0_0000_0300, 3'b001, 2'b00, 0, 0, 0, 5, 1);
    checkOutput("sticky_clear_valid", fault_valid_o, 1);
    checkOutput("sticky_clear_addr", fault_addr_o, 34'h300);

    // Randomized traffic with backpressure, flushes and fault clears
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if (!mdlPending && $urandom_range(0, 7) == 0) randomConfig();
      req_valid_i   = ($urandom_range(0, 2) != 0);
      req_addr_i    = randAddr();
      req_access_i  = 3'($urandom_range(0, 7));
      req_priv_i    = 2'($urandom_range(0, 3));
      rsp_ready_i   = ($urandom_range(0, 3) != 0);
      flush_i       = ($urandom_range(0, 24) == 0);
      fault_clear_i = ($urandom_range(0, 19) == 0);
    end
    @(posedge clk);
    #1;
    req_valid_i   = 1'b0;
    rsp_ready_i   = 1'b1;
    flush_i       = 1'b0;
    fault_clear_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
